// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared constants and loader state encoding for the 16-bit CPU |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int N      = 16;
  localparam int ADDR_W = 8;
  localparam int CHK_W  = 16;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_LO = 4'd1,
    ST_LEN_HI = 4'd2,
    ST_DAT_LO = 4'd3,
    ST_DAT_HI = 4'd4,
    ST_CHK_LO = 4'd5,
    ST_CHK_HI = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } loader_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/byte_pair_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_pair_assembler: latches a low byte, emits {hi, lo} on the high    |
// | byte with a word-valid strobe. Revision: 1.0                           |
// +----------------------------------------------------------------------+
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_fire,
  input  logic        hi_phase,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= 8'd0;
    end else if (byte_fire && !hi_phase) begin
      r_lo <= byte_in;
    end
  end

  // Word is presented combinationally so the FSM can act in the handshake cycle.
  assign word       = {byte_in, r_lo};
  assign word_valid = byte_fire && hi_phase;

endmodule : byte_pair_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader: byte-stream program loader for the instruction memory    |
// | write port, with length check, checksum and CPU hold. Revision: 1.0   |
// +----------------------------------------------------------------------+
module imem_loader #(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  import cpu_pkg::*;

  loader_state_t     r_state;
  loader_state_t     w_next;

  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_len;
  logic [CHK_W-1:0]  r_acc;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [N-1:0]      r_wdata;

  logic              w_fire;
  logic              w_hi_phase;
  logic              w_start_ok;
  logic [15:0]       w_word;
  logic              w_word_valid;
  logic [ADDR_W:0]   w_idx_inc;
  logic              w_len_over;
  logic              w_len_zero;
  logic              w_last;
  logic              w_chk_ok;

  assign w_fire     = byte_valid && byte_ready;
  assign w_hi_phase = (r_state == ST_LEN_HI) || (r_state == ST_DAT_HI) ||
                      (r_state == ST_CHK_HI);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERR));

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_fire  (w_fire),
    .hi_phase   (w_hi_phase),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  // Index is one bit wider than the address so LEN == DEPTH terminates cleanly.
  assign w_idx_inc  = r_idx + {{ADDR_W{1'b0}}, 1'b1};
  assign w_len_over = (32'(w_word) > DEPTH);
  assign w_len_zero = (w_word == 16'd0);
  assign w_last     = (w_idx_inc == r_len);
  assign w_chk_ok   = (w_word == r_acc);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_fire) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_fire) begin
          if (w_len_over)      w_next = ST_ERR;
          else if (w_len_zero) w_next = ST_CHK_LO;
          else                 w_next = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        if (w_fire) w_next = ST_DAT_HI;
      end
      ST_DAT_HI: begin
        if (w_fire) w_next = w_last ? ST_CHK_LO : ST_DAT_LO;
      end
      ST_CHK_LO: begin
        if (w_fire) w_next = ST_CHK_HI;
      end
      ST_CHK_HI: begin
        if (w_fire) w_next = w_chk_ok ? ST_DONE : ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Moore outputs; hold stays up through ERR so a corrupt image never runs.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_DAT_LO, ST_DAT_HI, ST_CHK_LO, ST_CHK_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      ST_ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, checksum and memory write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_acc   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_idx <= '0;
        r_acc <= '0;
      end
      if (w_fire && (r_state == ST_LEN_HI)) begin
        r_len <= w_word[ADDR_W:0];
      end
      if (w_word_valid && (r_state == ST_DAT_HI)) begin
        r_we    <= 1'b1;
        r_addr  <= r_idx[ADDR_W-1:0];
        r_wdata <= w_word;
        r_acc   <= r_acc + w_word;
        r_idx   <= w_idx_inc;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader: directed self-checking bench for imem_loader          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mem_model [0:255];
  int          wr_cnt = 0;
  int          b2b_cnt = 0;
  logic [7:0]  last_addr = 8'd0;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.N(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt    = wr_cnt + 1;
      mem_model[mem_addr] = mem_wdata;
      last_addr = mem_addr;
      if (prev_we) b2b_cnt = b2b_cnt + 1;
    end
    prev_we = mem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      check("byte_timeout", 32'(t), 32'd0);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_mon();
    wr_cnt  = 0;
    b2b_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] sum;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_we",    32'(mem_we),     0);
    check("rst_hold",  32'(cpu_hold),   0);
    check("rst_busy",  32'(busy),       0);
    check("rst_flags", {30'd0, done, error}, 0);
    check("rst_addr",  32'(mem_addr),   0);
    check("rst_wdata", 32'(mem_wdata),  0);
    @(negedge clk);
    rst = 1'b0;

    // Basic load
    clear_mon();
    pulse_start();
    check("start_ready", 32'(byte_ready), 1);
    check("start_hold",  32'(cpu_hold),   1);
    check("start_busy",  32'(busy),       1);
    send_word(16'h0003, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 1);
    send_word(16'h0001, 0);
    send_word(16'hBE02, 0);
    check("basic_done",  32'(done),     1);
    check("basic_err",   32'(error),    0);
    check("basic_hold",  32'(cpu_hold), 0);
    check("basic_busy",  32'(busy),     0);
    check("basic_wrcnt", 32'(wr_cnt),   3);
    check("basic_m0",    32'(mem_model[0]), 32'h1234);
    check("basic_m1",    32'(mem_model[1]), 32'hABCD);
    check("basic_m2",    32'(mem_model[2]), 32'h0001);
    check("basic_b2b",   32'(b2b_cnt),  0);

    // Bad checksum
    clear_mon();
    pulse_start();
    check("restart_done_clr", 32'(done), 0);
    send_word(16'h0003, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h0001, 0);
    send_word(16'hBE03, 0);
    check("badchk_err",   32'(error),    1);
    check("badchk_done",  32'(done),     0);
    check("badchk_hold",  32'(cpu_hold), 1);
    check("badchk_wrcnt", 32'(wr_cnt),   3);

    // Zero length
    clear_mon();
    pulse_start();
    check("err_clr_on_start", 32'(error),    0);
    check("hold_on_start",    32'(cpu_hold), 1);
    send_word(16'h0000, 0);
    send_word(16'h0000, 0);
    check("zero_done",  32'(done),   1);
    check("zero_wrcnt", 32'(wr_cnt), 0);

    // Overflow: LEN = 257
    pulse_start();
    send_word(16'h0101, 0);
    check("ovf_err",   32'(error),      1);
    check("ovf_ready", 32'(byte_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_ready_later", 32'(byte_ready), 0);
    check("ovf_hold",        32'(cpu_hold),   1);

    // Full-depth load with random gaps
    clear_mon();
    pulse_start();
    check("err_clr_on_start2", 32'(error), 0);
    sum = 16'h0000;
    send_word(16'd256, $urandom_range(0, 5));
    for (int i = 0; i < 256; i++) begin
      w   = 16'(i * 257 + 16'h9357);
      sum = sum + w;
      send_word(w, $urandom_range(0, 5));
    end
    send_word(sum, $urandom_range(0, 5));
    check("full_done",  32'(done),      1);
    check("full_wrcnt", 32'(wr_cnt),    256);
    check("full_last",  32'(last_addr), 255);
    check("full_m255",  32'(mem_model[255]), 32'(16'(255 * 257 + 16'h9357)));
    check("full_m0",    32'(mem_model[0]),   32'h9357);
    check("full_b2b",   32'(b2b_cnt),   0);

    // start while busy is ignored
    clear_mon();
    pulse_start();
    send_word(16'h0004, 0);
    send_word(16'h1111, 0);
    pulse_start();
    check("ign_busy", 32'(busy), 1);
    send_word(16'h2222, 0);
    send_word(16'h3333, 0);
    send_word(16'h4444, 0);
    send_word(16'hAAAA, 0);
    check("ign_done",  32'(done),         1);
    check("ign_wrcnt", 32'(wr_cnt),       4);
    check("ign_m3",    32'(mem_model[3]), 32'h4444);
    check("ign_last",  32'(last_addr),    3);

    // Reset mid-load after two of four words
    clear_mon();
    pulse_start();
    send_word(16'h0004, 0);
    send_word(16'h5555, 0);
    send_word(16'h6666, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_hold",  32'(cpu_hold),  0);
    check("mid_rst_ready", 32'(byte_ready), 0);
    check("mid_rst_busy",  32'(busy),      0);
    check("mid_rst_addr",  32'(mem_addr),  0);
    check("mid_rst_wdata", 32'(mem_wdata), 0);
    check("mid_rst_we",    32'(mem_we),    0);
    @(negedge clk);
    rst        = 1'b0;
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    check("mid_rst_wrcnt", 32'(wr_cnt), 2);

    // Fresh load after reset
    clear_mon();
    pulse_start();
    send_word(16'h0001, 0);
    send_word(16'hCAFE, 0);
    send_word(16'hCAFE, 0);
    check("fresh_done",  32'(done),         1);
    check("fresh_wrcnt", 32'(wr_cnt),       1);
    check("fresh_m0",    32'(mem_model[0]), 32'hCAFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
